// File: rtl/pixel_readout.sv
// Pixel-pair readout: assembles a two-row frame from read0/read1 strobes and
// queues packed frames in a first-word-fall-through FIFO with sticky error flags.
module pixel_readout #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read0,
  input  logic                  read1,
  input  logic                  erase,
  input  logic [DATA_W-1:0]     data_in1,
  input  logic [DATA_W-1:0]     data_in2,
  output logic [4*DATA_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                  overflow,
  output logic                  seq_error,
  input  logic                  err_clear
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned PAIR_W = 2 * DATA_W;
  localparam int unsigned WORD_W = 4 * DATA_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ROW0 = 1'b1
  } state_e;

  state_e              state_q;
  logic                read0_q;
  logic                read1_q;
  logic [PAIR_W-1:0]   hold_q;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;
  logic                overflow_q;
  logic                seq_error_q;

  logic                rise0_c;
  logic                rise1_c;
  logic                push_c;
  logic                seq_err_c;
  logic                full_c;
  logic                empty_c;
  logic                pop_c;
  logic                accept_c;
  logic                drop_c;
  logic [WORD_W-1:0]   push_word_c;

  // Edge detection and event decode; erase masks every strobe in its cycle.
  assign rise0_c     = read0 & ~read0_q;
  assign rise1_c     = read1 & ~read1_q;
  assign push_c      = (state_q == S_ROW0) && rise1_c && !erase;
  assign seq_err_c   = (state_q == S_IDLE) && rise1_c && !erase;
  assign push_word_c = {data_in2, data_in1, hold_q};

  assign empty_c  = (count_q == '0);
  assign full_c   = (count_q == CW'(DEPTH));
  assign pop_c    = !empty_c && out_ready;
  assign accept_c = push_c && (!full_c || pop_c);
  assign drop_c   = push_c && full_c && !pop_c;

  assign out_valid  = !empty_c;
  assign out_data   = empty_c ? '0 : mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign seq_error  = seq_error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read0_q <= 1'b0;
      read1_q <= 1'b0;
    end else begin
      read0_q <= read0;
      read1_q <= read1;
    end
  end

  // Capture FSM; a simultaneous read0 rise is ignored whenever read1 rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
    end else if (erase) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise0_c && !rise1_c) begin
            hold_q  <= {data_in2, data_in1};
            state_q <= S_ROW0;
          end
        end
        S_ROW0: begin
          if (rise1_c) begin
            hold_q  <= '0;
            state_q <= S_IDLE;
          end else if (rise0_c) begin
            hold_q  <= {data_in2, data_in1};
          end
        end
        default: begin
          state_q <= S_IDLE;
          hold_q  <= '0;
        end
      endcase
    end
  end

  // Storage array carries no reset; out_data is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem_q[wr_ptr_q] <= push_word_c;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({accept_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Sticky flags: a setting event outranks err_clear in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      seq_error_q <= 1'b0;
    end else begin
      if (drop_c) begin
        overflow_q <= 1'b1;
      end else if (err_clear) begin
        overflow_q <= 1'b0;
      end
      if (seq_err_c) begin
        seq_error_q <= 1'b1;
      end else if (err_clear) begin
        seq_error_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: expected frames go into a scoreboard queue
// and a negedge monitor checks every word the DUT hands over.
module tb_pixel_readout;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic        clk;
  logic        reset;
  logic        read0;
  logic        read1;
  logic        erase;
  logic [7:0]  data_in1;
  logic [7:0]  data_in2;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        seq_error;
  logic        err_clear;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  pixel_readout #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .read0      (read0),
    .read1      (read1),
    .erase      (erase),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .seq_error  (seq_error),
    .err_clear  (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: every handshake must deliver the oldest outstanding frame.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got 0x%08h expected no word", out_data);
      end else begin
        chk("sb_word", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe0(input logic [7:0] d1, input logic [7:0] d2);
    read0 = 1'b1; data_in1 = d1; data_in2 = d2;
    cyc();
    read0 = 1'b0;
    cyc();
  endtask

  task automatic strobe1(input logic [7:0] d1, input logic [7:0] d2);
    read1 = 1'b1; data_in1 = d1; data_in2 = d2;
    cyc();
    read1 = 1'b0;
    cyc();
  endtask

  // w = {row1col2, row1col1, row0col2, row0col1}
  task automatic frame(input logic [31:0] w, input bit expect_push);
    strobe0(w[7:0], w[15:8]);
    if (expect_push) exp_q.push_back(w);
    strobe1(w[23:16], w[31:24]);
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    cyc();
    err_clear = 1'b0;
    cyc();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (fifo_count == 3'd0) break;
      cyc();
    end
    chk("drain_count", 32'(fifo_count), 32'd0);
    out_ready = 1'b0;
  endtask

  logic [31:0] batch_a [5];
  logic [31:0] batch_b [5];

  initial begin
    batch_a = '{32'hA4A3A2A1, 32'hB4B3B2B1, 32'hC4C3C2C1, 32'hD4D3D2D1, 32'hE4E3E2E1};
    batch_b = '{32'h14131211, 32'h24232221, 32'h34333231, 32'h44434241, 32'h54535251};
    n_checks = 0; n_pass = 0;
    reset = 1'b1; read0 = 1'b0; read1 = 1'b0; erase = 1'b0;
    data_in1 = '0; data_in2 = '0; out_ready = 1'b1; err_clear = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_flags", {30'd0, overflow, seq_error}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // Basic frame and FWFT latency.
    strobe0(8'h11, 8'h22);
    read1 = 1'b1; data_in1 = 8'h33; data_in2 = 8'h44;
    exp_q.push_back(32'h44332211);
    chk("lat_valid_n", 32'(out_valid), 32'd0);
    cyc();
    chk("lat_valid_n1", 32'(out_valid), 32'd1);
    chk("lat_count_n1", 32'(fifo_count), 32'd1);
    read1 = 1'b0;
    cyc();
    chk("basic_count_after_pop", 32'(fifo_count), 32'd0);

    // Overflow with consumer stalled; fifth frame dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) frame(batch_a[i], i < 4);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("stall_head", out_data, 32'hA4A3A2A1);
    cyc();
    chk("stall_head_stable", out_data, 32'hA4A3A2A1);
    drain();
    chk("ovf_sb_empty", 32'(exp_q.size()), 32'd0);
    clear_errors();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // read1 without read0.
    strobe1(8'h01, 8'h02);
    chk("seq_set", 32'(seq_error), 32'd1);
    chk("seq_no_push", 32'(fifo_count), 32'd0);
    clear_errors();
    chk("seq_cleared", 32'(seq_error), 32'd0);

    // Erase aborts the partial frame.
    strobe0(8'h61, 8'h62);
    erase = 1'b1; cyc(); erase = 1'b0; cyc();
    strobe1(8'h63, 8'h64);
    chk("erase_seq", 32'(seq_error), 32'd1);
    chk("erase_no_push", 32'(fifo_count), 32'd0);
    clear_errors();

    // Simultaneous rises in ROW0 complete the frame.
    out_ready = 1'b1;
    strobe0(8'h71, 8'h72);
    read0 = 1'b1; read1 = 1'b1; data_in1 = 8'h73; data_in2 = 8'h74;
    exp_q.push_back(32'h74737271);
    cyc();
    read0 = 1'b0; read1 = 1'b0;
    cyc(); cyc();
    chk("simul_row0_count", 32'(fifo_count), 32'd0);
    // Simultaneous rises in IDLE are a sequence error.
    read0 = 1'b1; read1 = 1'b1;
    cyc();
    read0 = 1'b0; read1 = 1'b0;
    cyc();
    chk("simul_idle_seq", 32'(seq_error), 32'd1);
    chk("simul_idle_count", 32'(fifo_count), 32'd0);
    clear_errors();
    // Erase outranks read1 in the same cycle.
    strobe0(8'h81, 8'h82);
    read1 = 1'b1; erase = 1'b1;
    cyc();
    read1 = 1'b0; erase = 1'b0;
    cyc();
    chk("erase_prio_seq", 32'(seq_error), 32'd0);
    chk("erase_prio_count", 32'(fifo_count), 32'd0);
    // Setting event wins over err_clear.
    read1 = 1'b1; err_clear = 1'b1;
    cyc();
    read1 = 1'b0; err_clear = 1'b0;
    cyc();
    chk("set_beats_clear", 32'(seq_error), 32'd1);
    clear_errors();

    // Full FIFO with push and pop in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) frame(batch_b[i], 1'b1);
    chk("full_count", 32'(fifo_count), 32'd4);
    strobe0(8'h51, 8'h52);
    read1 = 1'b1; data_in1 = 8'h53; data_in2 = 8'h54; out_ready = 1'b1;
    exp_q.push_back(batch_b[4]);
    cyc();
    read1 = 1'b0; out_ready = 1'b0;
    chk("full_pushpop_count", 32'(fifo_count), 32'd4);
    chk("full_pushpop_ovf", 32'(overflow), 32'd0);
    chk("full_pushpop_head", out_data, 32'h24232221);
    cyc();
    drain();
    chk("full_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in ROW0 with two words stored and seq_error set.
    strobe1(8'h00, 8'h00);
    frame(32'h0D0C0B0A, 1'b1);
    frame(32'h1D1C1B1A, 1'b1);
    strobe0(8'h91, 8'h92);
    chk("pre_rst_count", 32'(fifo_count), 32'd2);
    chk("pre_rst_seq", 32'(seq_error), 32'd1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_flags", {30'd0, overflow, seq_error}, 32'd0);
    read1 = 1'b1; data_in1 = 8'h93; data_in2 = 8'h94;
    cyc();
    reset = 1'b0;
    cyc();
    read1 = 1'b0;
    chk("post_rst_seq", 32'(seq_error), 32'd1);
    chk("post_rst_no_push", 32'(fifo_count), 32'd0);
    cyc();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_readout.md
PIXEL_READOUT -- requirements
Module: pixel_readout

Interface
REQ-001 Parameter DATA_W, default 8: width of one pixel sample.
REQ-002 Parameter DEPTH, default 4: frame FIFO depth in words; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 read0  input  1  row-0 read strobe from pixel state machine.
REQ-006 read1  input  1  row-1 read strobe from pixel state machine.
REQ-007 erase  input  1  erase-phase strobe; aborts any partial frame.
REQ-008 data_in1  input  DATA_W  column-1 pixel value from pixel array.
REQ-009 data_in2  input  DATA_W  column-2 pixel value from pixel array.
REQ-010 out_data  output  4*DATA_W  packed frame {row1col2, row1col1, row0col2, row0col1}.
REQ-011 out_valid  output  1  out_data holds a valid frame.
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 fifo_count  output  clog2(DEPTH)+1  number of stored frames.
REQ-014 overflow  output  1  sticky: a completed frame was dropped.
REQ-015 seq_error  output  1  sticky: read1 arrived without a preceding read0.
REQ-016 err_clear  input  1  synchronous clear of overflow and seq_error.

Function
REQ-017 Strobe edges SHALL be detected with registered copies: rise = strobe AND NOT strobe_q; only rising edges act.
REQ-018 data_in1/data_in2 SHALL be sampled in the same cycle as the rise of read0 or read1.
REQ-019 Capture FSM SHALL have states IDLE and ROW0; reset state IDLE.
REQ-020 IDLE + read0 rise: store row-0 pair in holding register, go to ROW0.
REQ-021 ROW0 + read0 rise: overwrite holding register, stay ROW0.
REQ-022 ROW0 + read1 rise: form packed word from holding register and current inputs, request FIFO push, go IDLE.
REQ-023 IDLE + read1 rise: no push, set seq_error, stay IDLE.
REQ-024 erase high in any state SHALL force IDLE and discard holding register; erase takes priority over read0/read1 in the same cycle.
REQ-025 Simultaneous read0 and read1 rises SHALL be treated as a seq_error in IDLE, or as a read1 rise in ROW0 (read0 ignored).
REQ-026 FIFO SHALL be first-word-fall-through: out_valid = (fifo_count != 0); out_data = oldest word.
REQ-027 Pop SHALL occur when out_valid AND out_ready; out_data SHALL be stable while out_valid AND NOT out_ready.
REQ-028 Latency: push requested in cycle N into empty FIFO SHALL give out_valid=1 and the word on out_data in cycle N+1.
REQ-029 Push when fifo_count < DEPTH: accepted, count +1 (unchanged if simultaneous pop).
REQ-030 Push when full with simultaneous pop: accepted, count stays DEPTH.
REQ-031 Push when full without pop: word dropped, FIFO unchanged, overflow set.
REQ-032 Pop when empty SHALL have no effect; count never underflows.
REQ-033 Read/write pointers SHALL wrap modulo DEPTH.
REQ-034 err_clear SHALL clear both sticky flags; a setting event in the same cycle SHALL win.

Reset
REQ-035 On reset assertion, immediately: FSM=IDLE, fifo_count=0, out_valid=0, overflow=0, seq_error=0, strobe registers=0, pointers=0.
REQ-036 out_data reset value SHALL be 0.
REQ-037 Reset mid-frame (in ROW0) SHALL discard the partial frame; no push after deassertion until a new read0 rise.
REQ-038 First rising clk edge after deassertion SHALL operate normally; a strobe already high at deassertion counts as a rise.

Verification
REQ-039 read0 rise with data 0x11/0x22, then read1 rise with 0x33/0x44, out_ready=1 -> out_valid one cycle after read1 rise, out_data=0x44332211, count returns to 0 after pop.
REQ-040 out_ready=0, five complete frames, DEPTH=4 -> fifo_count=4, overflow=1, first four frames popped in order afterwards, fifth absent.
REQ-041 read1 rise with no prior read0 -> no push, seq_error=1; err_clear pulse -> seq_error=0.
REQ-042 read0 rise, then erase, then read1 rise -> no push, seq_error=1, FSM IDLE.
REQ-043 FIFO full, push and pop in same cycle -> count stays 4, oldest word popped, new word at tail.
REQ-044 reset asserted while in ROW0 and FIFO holding 2 words -> all outputs 0 immediately; subsequent read1 alone -> seq_error=1, no push.
